// File: rtl/yarvi_trace_ctrl_pkg.sv
// Shared definitions for the retire-trace capture controller: widths, FSM encodings, record layout.
package yarvi_trace_ctrl_pkg;

    localparam int unsigned VMSB        = 31;
    localparam int unsigned XW          = VMSB + 1;
    localparam int unsigned TRACE_REC_W = 2 * XW + 32 + 5;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ARMED   = 3'd1;
    localparam logic [2:0] ST_CAPTURE = 3'd2;
    localparam logic [2:0] ST_DRAIN   = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    typedef struct packed {
        logic [XW-1:0] pc;
        logic [31:0]   insn;
        logic [4:0]    wb_rd;
        logic [XW-1:0] wb_val;
    } trace_rec_t;

endpackage

// File: rtl/yarvi_trace_fifo.sv
// Registered FIFO with wrap-bit pointers, head-data output and synchronous flush.
module yarvi_trace_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned W     = 8
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               din,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [W-1:0]               dout
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];
    logic         do_push;
    logic         do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
        end else if (do_push && !flush) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/yarvi_trace_ctrl.sv
// Trace capture controller: arm, trigger on PC match or first retire, capture a window, drain to printer.
module yarvi_trace_ctrl
    import yarvi_trace_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CW    = 16
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          arm,
    input  logic          abort,
    input  logic          trig_en,
    input  logic [VMSB:0] trig_pc,
    input  logic [CW-1:0] post_count,
    input  logic          ret_valid,
    input  logic [VMSB:0] ret_pc,
    input  logic [31:0]   ret_insn,
    input  logic [4:0]    ret_wb_rd,
    input  logic [VMSB:0] ret_wb_val,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [VMSB:0] out_pc,
    output logic [31:0]   out_insn,
    output logic [4:0]    out_wb_rd,
    output logic [VMSB:0] out_wb_val,
    output logic [2:0]    state,
    output logic          overflow,
    output logic [CW-1:0] dropped,
    output logic [CW-1:0] remaining
);
    localparam int unsigned CNTW = $clog2(DEPTH) + 1;

    trace_rec_t    in_rec;
    trace_rec_t    head_rec;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CNTW-1:0] fifo_count;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_flush;
    logic          hit_c;
    logic          drop_c;
    logic [2:0]    state_nxt;
    logic [CW-1:0] remaining_nxt;
    logic [CW-1:0] dropped_nxt;
    logic          overflow_nxt;

    assign in_rec     = '{pc: ret_pc, insn: ret_insn, wb_rd: ret_wb_rd, wb_val: ret_wb_val};
    assign out_valid  = !fifo_empty;
    assign out_pc     = head_rec.pc;
    assign out_insn   = head_rec.insn;
    assign out_wb_rd  = head_rec.wb_rd;
    assign out_wb_val = head_rec.wb_val;

    yarvi_trace_fifo #(.DEPTH(DEPTH), .W(TRACE_REC_W)) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .flush   (fifo_flush),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .din     (in_rec),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count),
        .dout    (head_rec)
    );

    // Next-state, counter and FIFO-control decode.
    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        overflow_nxt  = overflow;
        dropped_nxt   = dropped;
        hit_c         = ret_valid && (!trig_en || (ret_pc == trig_pc));
        fifo_pop      = out_valid && out_ready;
        fifo_flush    = abort;
        fifo_push     = !abort && (((state == ST_ARMED) && hit_c) ||
                                   ((state == ST_CAPTURE) && ret_valid));
        drop_c        = fifo_push && fifo_full && !fifo_pop;

        if (abort) begin
            state_nxt     = ST_IDLE;
            remaining_nxt = '0;
        end else if (fifo_push) begin
            // The window counts retires, so dropped records still consume it.
            remaining_nxt = remaining - CW'(1);
            state_nxt     = (remaining == CW'(1)) ? ST_DRAIN : ST_CAPTURE;
            if (drop_c) begin
                overflow_nxt = 1'b1;
                if (dropped != '1) dropped_nxt = dropped + CW'(1);
            end
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (arm) begin
                        state_nxt     = ST_ARMED;
                        remaining_nxt = (post_count == '0) ? CW'(1) : post_count;
                        overflow_nxt  = 1'b0;
                        dropped_nxt   = '0;
                    end
                end
                ST_DRAIN: begin
                    if (fifo_empty || (fifo_pop && (fifo_count == CNTW'(1))))
                        state_nxt = ST_DONE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            remaining <= '0;
            overflow  <= 1'b0;
            dropped   <= '0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
            overflow  <= overflow_nxt;
            dropped   <= dropped_nxt;
        end
    end

endmodule
